fpa_seq_ctrl: RTL and testbench

Sequencer for the floating-point addition datapath: walks a single-port operand ROM in pairs, latches both operands, drives the pipelined FP adder with an enable/valid handshake, and writes each sum into the result RAM. It replaces free-running `#delay` sequencing with a clocked FSM, a per-operation timeout, and a clean external read-back path once the batch is finished.

---
 rtl/fpa_pkg.sv | 23 ++
 rtl/fpa_timeout_cnt.sv | 37 +++
 rtl/fpa_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_fpa_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpa_pkg.sv
// Shared types and constants for the floating-point addition sequencer.
package fpa_pkg;

    localparam int FP_W = 32;

    localparam logic EN_ACTIVE    = 1'b1;
    localparam logic VALID_ACTIVE = 1'b1;
    localparam logic RAM_WRITE    = 1'b1;
    localparam logic RAM_READ     = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH_A = 4'd1,
        ST_FETCH_B = 4'd2,
        ST_ISSUE   = 4'd3,
        ST_WAIT    = 4'd4,
        ST_WRITE   = 4'd5,
        ST_NEXT    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } fpa_seq_state_t;

endpackage

// File: rtl/fpa_timeout_cnt.sv
// Per-operation watchdog: cleared on issue, counts while waiting for the adder.
module fpa_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int              CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the edge where the count reaches TIMEOUT-1, so the error
    // state is entered exactly TIMEOUT cycles after the issue cycle.
    assign expire_o = en_i && !load_i && (cnt_d == LAST);

endmodule

// File: rtl/fpa_seq_ctrl.sv
// Clocked sequencer for the FP-add datapath: fetch operand pairs from ROM,
// issue them to the pipelined adder, write sums to RAM, then expose RAM for read-back.
module fpa_seq_ctrl
    import fpa_pkg::*;
#(
    parameter int ROM_AW    = 3,
    parameter int RAM_AW    = 2,
    parameter int NUM_PAIRS = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_oe,
    input  logic [31:0]       rom_data,
    output logic [31:0]       add_op1,
    output logic [31:0]       add_op2,
    output logic              add_en,
    input  logic              add_valid,
    input  logic [31:0]       add_sum,
    input  logic [RAM_AW-1:0] rd_addr,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_rw,
    output logic              ram_oe,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [RAM_AW-1:0] pair_idx
);
    localparam logic [RAM_AW-1:0] LAST_PAIR = RAM_AW'(NUM_PAIRS - 1);

    fpa_seq_state_t    state_q, state_d;
    logic [RAM_AW-1:0] pair_q, pair_d;
    logic [FP_W-1:0]   op1_q, op2_q, sum_q;
    logic              cnt_load, cnt_en, cnt_expire;
    logic              host_side;
    logic [ROM_AW-1:0] rom_base;

    fpa_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .load_i   (cnt_load),
        .en_i     (cnt_en),
        .expire_o (cnt_expire)
    );

    always_comb begin
        state_d  = state_q;
        pair_d   = pair_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_FETCH_A;
                    pair_d  = '0;
                end
            end
            ST_FETCH_A: state_d = ST_FETCH_B;
            ST_FETCH_B: state_d = ST_ISSUE;
            ST_ISSUE: begin
                state_d  = ST_WAIT;
                cnt_load = 1'b1;
            end
            // A valid arriving on the expiry edge still wins.
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (add_valid == VALID_ACTIVE) begin
                    state_d = ST_WRITE;
                end else if (cnt_expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_WRITE: state_d = ST_NEXT;
            ST_NEXT: begin
                if (pair_q == LAST_PAIR) begin
                    state_d = ST_DONE;
                end else begin
                    pair_d  = pair_q + 1'b1;
                    state_d = ST_FETCH_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pair_q  <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op1_q <= '0;
            op2_q <= '0;
            sum_q <= '0;
        end else begin
            if (state_q == ST_FETCH_A) op1_q <= rom_data;
            if (state_q == ST_FETCH_B) op2_q <= rom_data;
            if (state_q == ST_WAIT && add_valid == VALID_ACTIVE) sum_q <= add_sum;
        end
    end

    assign host_side = state_q inside {ST_IDLE, ST_DONE, ST_ERR};
    assign rom_base  = ROM_AW'({pair_q, 1'b0});

    always_comb begin
        rom_addr = '0;
        rom_oe   = 1'b0;
        if (state_q == ST_FETCH_A) begin
            rom_addr = rom_base;
            rom_oe   = 1'b1;
        end else if (state_q == ST_FETCH_B) begin
            rom_addr = rom_base | ROM_AW'(1);
            rom_oe   = 1'b1;
        end
    end

    assign add_op1   = op1_q;
    assign add_op2   = op2_q;
    assign add_en    = (state_q == ST_ISSUE) ? EN_ACTIVE : ~EN_ACTIVE;
    assign ram_rw    = (state_q == ST_WRITE) ? RAM_WRITE : RAM_READ;
    assign ram_wdata = sum_q;
    // Once idle the RAM address belongs to the external reader.
    assign ram_oe    = host_side;
    assign ram_addr  = host_side ? rd_addr : pair_q;
    assign busy      = !host_side;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign pair_idx  = pair_q;

endmodule

// File: tb/tb_fpa_seq_ctrl.sv
// Directed bench for fpa_seq_ctrl: ROM/adder/RAM models with a write scoreboard.
module tb_fpa_seq_ctrl;
    localparam int ROM_AW    = 3;
    localparam int RAM_AW    = 2;
    localparam int NUM_PAIRS = 3;
    localparam int TIMEOUT   = 64;
    localparam int LAT       = 4;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [ROM_AW-1:0] rom_addr;
    logic              rom_oe;
    logic [31:0]       rom_data;
    logic [31:0]       add_op1, add_op2;
    logic              add_en, add_valid;
    logic [31:0]       add_sum;
    logic [RAM_AW-1:0] rd_addr, ram_addr, pair_idx;
    logic [31:0]       ram_wdata;
    logic              ram_rw, ram_oe, busy, done, error;

    int total = 0;
    int bad   = 0;
    int n;

    logic [31:0] rom [8] = '{32'h3F800000, 32'h3E800000, 32'h40400000, 32'h41200000,
                             32'h3EA00000, 32'h3F600000, 32'h00000000, 32'h00000000};
    logic [31:0] exp_sum [3] = '{32'h3FA00000, 32'h41500000, 32'h3F980000};
    logic [31:0] ram_mem [4];

    logic [33:0]       sb [$];
    logic [RAM_AW-1:0] idx_log [$];
    logic [33:0]       exp_item;

    logic              stub_dead, spur;
    logic [LAT-1:0]    sr;
    logic [31:0]       stub_sum_q;

    always #5 clk = ~clk;

    fpa_seq_ctrl #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .NUM_PAIRS(NUM_PAIRS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_data(rom_data),
        .add_op1(add_op1), .add_op2(add_op2), .add_en(add_en),
        .add_valid(add_valid), .add_sum(add_sum),
        .rd_addr(rd_addr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rw(ram_rw), .ram_oe(ram_oe),
        .busy(busy), .done(done), .error(error), .pair_idx(pair_idx)
    );

    assign rom_data = rom[rom_addr];

    // Adder stub: known operand pairs map to their IEEE-754 sums, latency LAT.
    function automatic logic [31:0] fp_table(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h3E800000}: return 32'h3FA00000;
            {32'h40400000, 32'h41200000}: return 32'h41500000;
            {32'h3EA00000, 32'h3F600000}: return 32'h3F980000;
            default:                      return 32'hFFFFFFFF;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {sr[LAT-2:0], add_en & ~stub_dead};
            if (add_en) stub_sum_q <= fp_table(add_op1, add_op2);
        end
    end

    assign add_valid = sr[LAT-1] | spur;
    assign add_sum   = spur ? 32'hBAD0BAD0 : stub_sum_q;

    always @(posedge clk) begin
        if (ram_rw && !ram_oe) ram_mem[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && add_en) idx_log.push_back(pair_idx);
        if (!reset && ram_rw) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL wr_unexpected observed=%0h expected=none", {ram_addr, ram_wdata});
            end
            if (sb.size() != 0) begin
                exp_item = sb.pop_front();
                chk("ram_write", 64'({ram_addr, ram_wdata}), 64'(exp_item));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_batch(input int cnt);
        for (int i = 0; i < cnt; i++) sb.push_back({RAM_AW'(i), exp_sum[i]});
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        while (!(done || error) && cycles < 400) begin
            tick();
            cycles++;
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_rom_addr"}, 64'(rom_addr), 0);
        chk({tag, "_rom_oe"}, 64'(rom_oe), 0);
        chk({tag, "_add_en"}, 64'(add_en), 0);
        chk({tag, "_op1"}, 64'(add_op1), 0);
        chk({tag, "_op2"}, 64'(add_op2), 0);
        chk({tag, "_wdata"}, 64'(ram_wdata), 0);
        chk({tag, "_ram_rw"}, 64'(ram_rw), 0);
        chk({tag, "_ram_oe"}, 64'(ram_oe), 1);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_error"}, 64'(error), 0);
        chk({tag, "_pair_idx"}, 64'(pair_idx), 0);
    endtask

    task automatic readback(input string tag);
        @(negedge clk);
        for (int i = 0; i < NUM_PAIRS; i++) begin
            rd_addr = RAM_AW'(i);
            #1;
            chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(i));
            chk({tag, "_ram_oe"}, 64'(ram_oe), 1);
            chk({tag, "_ram_rw"}, 64'(ram_rw), 0);
            chk({tag, "_ram_data"}, 64'(ram_mem[i]), 64'(exp_sum[i]));
        end
        rd_addr = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rd_addr = '0; stub_dead = 1'b0; spur = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_rst("reset");
        @(negedge clk);
        reset = 1'b0;

        // Batch 1: nominal run and cycle count.
        push_batch(NUM_PAIRS);
        pulse_start();
        chk("b1_busy", 64'(busy), 1);
        chk("b1_rom_oe", 64'(rom_oe), 1);
        chk("b1_rom_addr0", 64'(rom_addr), 0);
        wait_end(n);
        chk("b1_cycles", 64'(n), 64'(NUM_PAIRS * (5 + LAT)));
        chk("b1_done", 64'(done), 1);
        chk("b1_error", 64'(error), 0);
        chk("b1_busy_end", 64'(busy), 0);
        chk("b1_sb_empty", 64'(sb.size()), 0);
        readback("rb1");

        // Batch 2: start while busy and a spurious valid during FETCH_A.
        idx_log.delete();
        push_batch(NUM_PAIRS);
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(rom_oe && rom_addr == 3'd2) && n < 100) begin
            tick();
            n++;
        end
        chk("b2_fetch_a1", 64'(rom_oe && rom_addr == 3'd2), 1);
        spur  = 1'b1;
        start = 1'b1;
        tick();
        spur  = 1'b0;
        start = 1'b0;
        wait_end(n);
        chk("b2_done", 64'(done), 1);
        chk("b2_idx_cnt", 64'(idx_log.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < idx_log.size()) chk("b2_idx_seq", 64'(idx_log[i]), 64'(i));
        end
        chk("b2_sb_empty", 64'(sb.size()), 0);

        // Timeout: adder never answers.
        stub_dead = 1'b1;
        pulse_start();
        n = 0;
        while (!add_en && n < 20) begin
            tick();
            n++;
        end
        chk("to_issue_seen", 64'(add_en), 1);
        n = 0;
        while (!error && n < 200) begin
            tick();
            n++;
        end
        chk("to_cycles", 64'(n), 64'(TIMEOUT));
        chk("to_error", 64'(error), 1);
        chk("to_done", 64'(done), 0);
        chk("to_busy", 64'(busy), 0);
        stub_dead = 1'b0;

        // Reset in WAIT of pair 1, then a fresh batch.
        push_batch(1);
        pulse_start();
        chk("rs_error_cleared", 64'(error), 0);
        n = 0;
        while (!(add_en && pair_idx == 2'd1) && n < 100) begin
            tick();
            n++;
        end
        chk("rs_issue1", 64'(add_en && pair_idx == 2'd1), 1);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk_rst("midrst");
        @(negedge clk);
        reset = 1'b0;
        chk("rs_sb_empty", 64'(sb.size()), 0);
        push_batch(NUM_PAIRS);
        pulse_start();
        wait_end(n);
        chk("rs_cycles", 64'(n), 64'(NUM_PAIRS * (5 + LAT)));
        chk("rs_done", 64'(done), 1);
        chk("rs_sb_done", 64'(sb.size()), 0);
        readback("rb2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
